// File: rtl/dla_layer_sequencer_pkg.sv
// Shared types and constants for the DLA layer sequencer: FSM states,
// default config width and the stock layer configs used to preload the table.
package dla_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        NEXT,
        DONE,
        ERR
    } state_t;

    localparam int DLA_CFG_W = 56;

    // Stock transfer_config words: pointwise conv on a 28x28 map, and depthwise.
    localparam logic [DLA_CFG_W-1:0] CFG_PW_28X28 = 56'h01_1C1C_0040_0040;
    localparam logic [DLA_CFG_W-1:0] CFG_DW       = 56'h02_1C1C_0040_0001;

endpackage

// File: rtl/dla_layer_sequencer_if.sv
// Host/DLA-facing signal bundle of the layer sequencer; master is the
// environment (host + DLA), slave is the sequencer.
interface dla_layer_sequencer_if #(
    parameter int CFG_W      = 56,
    parameter int MAX_LAYERS = 8,
    parameter int CYC_W      = 32
);
    localparam int AW = $clog2(MAX_LAYERS);

    logic             cfg_we;
    logic [AW-1:0]    cfg_waddr;
    logic [CFG_W-1:0] cfg_wdata;
    logic [AW:0]      num_layers;
    logic             run;
    logic             abort;
    logic             layer_done;
    logic             dla_start;
    logic [CFG_W-1:0] transfer_config;
    logic [AW-1:0]    layer_idx;
    logic             busy;
    logic             seq_done;
    logic             timeout_err;
    logic [CYC_W-1:0] cycle_count;

    modport master (
        output cfg_we, cfg_waddr, cfg_wdata, num_layers, run, abort, layer_done,
        input  dla_start, transfer_config, layer_idx, busy, seq_done, timeout_err, cycle_count
    );

    modport slave (
        input  cfg_we, cfg_waddr, cfg_wdata, num_layers, run, abort, layer_done,
        output dla_start, transfer_config, layer_idx, busy, seq_done, timeout_err, cycle_count
    );

endinterface

// File: rtl/dla_layer_sequencer_cfg_regfile.sv
// Per-layer transfer_config table: flop array with one synchronous write
// port and one combinational read port; write gating is done by the caller.
module dla_cfg_regfile #(
    parameter int CFG_W      = 56,
    parameter int MAX_LAYERS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [$clog2(MAX_LAYERS)-1:0] waddr,
    input  logic [CFG_W-1:0]              wdata,
    input  logic [$clog2(MAX_LAYERS)-1:0] raddr,
    output logic [CFG_W-1:0]              rdata
);

    logic [CFG_W-1:0] mem [MAX_LAYERS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_LAYERS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dla_layer_sequencer.sv
// Multi-layer run controller: walks the config table, pulses dla_start per
// layer, waits for layer_done, with abort, WAIT timeout and busy-cycle profiling.
module dla_layer_sequencer
    import dla_seq_pkg::*;
#(
    parameter int CFG_W          = DLA_CFG_W,
    parameter int MAX_LAYERS     = 8,
    parameter int CYC_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic                 clk,
    input logic                 rst,
    dla_layer_sequencer_if.slave bus
);

    localparam int            AW       = $clog2(MAX_LAYERS);
    localparam int            NW       = AW + 1;
    localparam logic [NW-1:0] MAX_N    = NW'(MAX_LAYERS);
    localparam logic [31:0]   TO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t           state, state_nx;
    logic             run_q;
    logic [NW-1:0]    num_q, n_lat;
    logic [AW-1:0]    idx;
    logic [CFG_W-1:0] cfg_rd, cfg_r;
    logic             start_r, terr;
    logic [CYC_W-1:0] cyc;
    logic [31:0]      wait_cnt;
    logic             busy_w, last_layer, wait_hit;

    assign busy_w     = (state != IDLE);
    assign last_layer = ({1'b0, idx} == (n_lat - NW'(1)));
    assign wait_hit   = (TIMEOUT_CYCLES != 0) && ((wait_cnt + 32'd1) == TO_LIMIT);

    dla_cfg_regfile #(.CFG_W(CFG_W), .MAX_LAYERS(MAX_LAYERS)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.cfg_we && !busy_w),
        .waddr (bus.cfg_waddr),
        .wdata (bus.cfg_wdata),
        .raddr (idx),
        .rdata (cfg_rd)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (run_q) state_nx = (num_q == '0) ? DONE : LOAD;
            LOAD:  state_nx = START;
            START: state_nx = WAIT;
            // layer_done coinciding with our own start pulse belongs to an earlier job
            WAIT: begin
                if (bus.layer_done && !start_r) state_nx = NEXT;
                else if (wait_hit)              state_nx = ERR;
            end
            NEXT:    state_nx = last_layer ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort && busy_w) state_nx = IDLE;
    end

    // run/num_layers pass through an input register first, so the accepted
    // run reaches LOAD one edge after it is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            num_q    <= '0;
            n_lat    <= '0;
            idx      <= '0;
            cfg_r    <= '0;
            start_r  <= 1'b0;
            terr     <= 1'b0;
            cyc      <= '0;
            wait_cnt <= '0;
        end else begin
            state   <= state_nx;
            run_q   <= bus.run && (state == IDLE);
            num_q   <= bus.num_layers;
            start_r <= (state == START) && (state_nx == WAIT);
            if (busy_w && (cyc != '1)) cyc <= cyc + CYC_W'(1);
            unique case (state)
                IDLE: if (run_q) begin
                    idx      <= '0;
                    cyc      <= '0;
                    terr     <= 1'b0;
                    wait_cnt <= '0;
                    n_lat    <= (num_q > MAX_N) ? MAX_N : num_q;
                end
                LOAD: if (state_nx == START) cfg_r <= cfg_rd;
                WAIT: wait_cnt <= wait_cnt + 32'd1;
                NEXT: begin
                    wait_cnt <= '0;
                    if (state_nx == LOAD) idx <= idx + AW'(1);
                end
                ERR:     if (!bus.abort) terr <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.dla_start       = start_r;
    assign bus.transfer_config = cfg_r;
    assign bus.layer_idx       = idx;
    assign bus.busy            = busy_w;
    assign bus.seq_done        = (state == DONE);
    assign bus.timeout_err     = terr;
    assign bus.cycle_count     = cyc;

endmodule

// File: tb/tb_dla_layer_sequencer.sv
// Directed bench for dla_layer_sequencer: timing of the two-layer run, empty and
// oversize runs, timeout, abort, ignored layer_done, config write gating, async reset.
module tb_dla_layer_sequencer;
    import dla_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;
    int   seq_cnt = 0;
    logic [55:0] exp_tab [8];

    always #5 clk = ~clk;

    dla_layer_sequencer_if #(.CFG_W(56), .MAX_LAYERS(8), .CYC_W(32)) bus ();

    dla_layer_sequencer #(
        .CFG_W(56), .MAX_LAYERS(8), .CYC_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.dla_start) start_cnt++;
        if (bus.seq_done)  seq_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (bus.dla_start) ok = 1'b1;
        end
    endtask

    task automatic wait_seq(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (bus.seq_done) ok = 1'b1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [55:0] d);
        bus.cfg_we = 1'b1; bus.cfg_waddr = a; bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] n);
        bus.run = 1'b1; bus.num_layers = n;
        tick();
        bus.run = 1'b0;
    endtask

    task automatic finish_layer(input string tag);
        bit ok;
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        wait_seq(6, ok);
        chk(tag, 64'(ok), 64'd1);
        tick();
    endtask

    initial begin
        bit ok;
        int s0, q0;
        bus.cfg_we = 0; bus.cfg_waddr = '0; bus.cfg_wdata = '0; bus.num_layers = '0;
        bus.run = 0; bus.abort = 0; bus.layer_done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_start", 64'(bus.dla_start), 64'd0);
        chk("rst_cfg", 64'(bus.transfer_config), 64'd0);
        chk("rst_cyc", 64'(bus.cycle_count), 64'd0);
        chk("rst_terr", 64'(bus.timeout_err), 64'd0);
        rst = 1'b0;
        tick();

        exp_tab[0] = CFG_PW_28X28;
        exp_tab[1] = CFG_DW;
        for (int i = 2; i < 8; i++) exp_tab[i] = {8'(i), 48'hC0FF_EE00_0000};
        for (int i = 0; i < 8; i++) wr(3'(i), exp_tab[i]);

        // Two-layer run: run sampled at edge k, config at k+2, start at k+3
        go(4'd2);
        chk("a_k_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("a_k1_busy", 64'(bus.busy), 64'd1);
        chk("a_k1_cfg", 64'(bus.transfer_config), 64'd0);
        tick();
        chk("a_k2_cfg", 64'(bus.transfer_config), 64'(CFG_PW_28X28));
        chk("a_k2_start", 64'(bus.dla_start), 64'd0);
        tick();
        chk("a_k3_start", 64'(bus.dla_start), 64'd1);
        tick();
        chk("a_k4_start", 64'(bus.dla_start), 64'd0);
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        tick();
        chk("a_j1_start", 64'(bus.dla_start), 64'd0);
        tick();
        chk("a_j2_cfg", 64'(bus.transfer_config), 64'(CFG_DW));
        chk("a_j2_idx", 64'(bus.layer_idx), 64'd1);
        chk("a_j2_start", 64'(bus.dla_start), 64'd0);
        tick();
        chk("a_j3_start", 64'(bus.dla_start), 64'd1);
        tick();
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        chk("a_next_seq", 64'(bus.seq_done), 64'd0);
        tick();
        chk("a_done_seq", 64'(bus.seq_done), 64'd1);
        chk("a_done_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("a_idle_seq", 64'(bus.seq_done), 64'd0);
        chk("a_idle_busy", 64'(bus.busy), 64'd0);
        chk("a_cyc", 64'(bus.cycle_count), 64'd11);
        chk("a_hold_cfg", 64'(bus.transfer_config), 64'(CFG_DW));

        // Zero layers: one busy cycle, seq_done, no start
        s0 = start_cnt;
        go(4'd0);
        tick();
        chk("z_busy", 64'(bus.busy), 64'd1);
        chk("z_seq", 64'(bus.seq_done), 64'd1);
        tick();
        chk("z_idle", 64'(bus.busy), 64'd0);
        chk("z_cyc", 64'(bus.cycle_count), 64'd1);
        chk("z_starts", 64'(start_cnt - s0), 64'd0);

        // num_layers=12 clamps to 8
        s0 = start_cnt;
        go(4'd12);
        for (int i = 0; i < 8; i++) begin
            wait_start(8, ok);
            chk("c_start_seen", 64'(ok), 64'd1);
            chk("c_idx", 64'(bus.layer_idx), 64'(i));
            chk("c_cfg", 64'(bus.transfer_config), 64'(exp_tab[i]));
            tick();
            bus.layer_done = 1'b1;
            tick();
            bus.layer_done = 1'b0;
        end
        wait_seq(4, ok);
        chk("c_seq", 64'(ok), 64'd1);
        chk("c_starts", 64'(start_cnt - s0), 64'd8);
        chk("c_last_idx", 64'(bus.layer_idx), 64'd7);
        tick();

        // Timeout: no layer_done for 16 WAIT cycles
        q0 = seq_cnt;
        go(4'd1);
        wait_start(8, ok);
        chk("t_start_seen", 64'(ok), 64'd1);
        repeat (16) tick();
        chk("t_err_busy", 64'(bus.busy), 64'd1);
        chk("t_err_flag0", 64'(bus.timeout_err), 64'd0);
        tick();
        chk("t_flag", 64'(bus.timeout_err), 64'd1);
        chk("t_idle", 64'(bus.busy), 64'd0);
        chk("t_no_seq", 64'(seq_cnt - q0), 64'd0);
        go(4'd1);
        chk("t_flag_held", 64'(bus.timeout_err), 64'd1);
        tick();
        chk("t_flag_clr", 64'(bus.timeout_err), 64'd0);
        wait_start(8, ok);
        tick();
        finish_layer("t_finish");

        // Abort together with layer_done in WAIT of layer 1
        go(4'd3);
        wait_start(8, ok);
        tick();
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        wait_start(8, ok);
        chk("b_idx1", 64'(bus.layer_idx), 64'd1);
        tick();
        bus.abort = 1'b1; bus.layer_done = 1'b1;
        tick();
        bus.abort = 1'b0; bus.layer_done = 1'b0;
        chk("b_idle", 64'(bus.busy), 64'd0);
        chk("b_idx_hold", 64'(bus.layer_idx), 64'd1);
        s0 = start_cnt; q0 = seq_cnt;
        repeat (6) tick();
        chk("b_no_start", 64'(start_cnt - s0), 64'd0);
        chk("b_no_seq", 64'(seq_cnt - q0), 64'd0);
        chk("b_no_terr", 64'(bus.timeout_err), 64'd0);

        // layer_done coincident with dla_start is ignored
        q0 = seq_cnt;
        go(4'd1);
        wait_start(8, ok);
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        repeat (3) tick();
        chk("d_still_busy", 64'(bus.busy), 64'd1);
        chk("d_no_seq", 64'(seq_cnt - q0), 64'd0);
        finish_layer("d_finish");

        // Write while busy is dropped
        go(4'd1);
        wait_start(8, ok);
        wr(3'd0, 56'hDE_ADBE_EF00_BAD0);
        finish_layer("w_finish");
        go(4'd1);
        wait_start(8, ok);
        chk("w_cfg_kept", 64'(bus.transfer_config), 64'(CFG_PW_28X28));
        tick();
        finish_layer("w_finish2");

        // Write and run in the same IDLE cycle: run sees the new word
        bus.cfg_we = 1'b1; bus.cfg_waddr = 3'd0; bus.cfg_wdata = 56'h5A_1234_5678_9ABC;
        bus.run = 1'b1; bus.num_layers = 4'd1;
        tick();
        bus.cfg_we = 1'b0; bus.run = 1'b0;
        wait_start(8, ok);
        chk("s_cfg_new", 64'(bus.transfer_config), 64'h5A_1234_5678_9ABC);
        tick();

        // Asynchronous reset mid-WAIT
        tick();
        #2 rst = 1'b1;
        #1;
        chk("r_busy", 64'(bus.busy), 64'd0);
        chk("r_cfg", 64'(bus.transfer_config), 64'd0);
        chk("r_cyc", 64'(bus.cycle_count), 64'd0);
        chk("r_start", 64'(bus.dla_start), 64'd0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dla_layer_sequencer.md
Name: dla_layer_sequencer

Overview:
Multi-layer run controller for the DLA datapath. It holds a small table of per-layer transfer_config words and issues one DLA start pulse per layer. After each pulse it waits for the DLA's all-done indication, then advances to the next layer. It sits between the host/testbench and the DLA in the top level, replacing the single post-reset start pulse and hard-wired config constant, and adds layer counting, abort, timeout detection and cycle profiling.

Parameters:
CFG_W, 56, width of one transfer_config word
MAX_LAYERS, 8, config table depth (power of two, >=2)
CYC_W, 32, width of the cycle profiling counter
TIMEOUT_CYCLES, 1048576, max cycles in WAIT per layer before error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  config table write strobe
cfg_waddr  in  $clog2(MAX_LAYERS)  table write address
cfg_wdata  in  CFG_W  table write data
num_layers  in  $clog2(MAX_LAYERS)+1  layers to run, sampled on accepted run
run  in  1  start-sequence request (level sampled in IDLE)
abort  in  1  abort current sequence
layer_done  in  1  DLA all-done pulse (all_done_main)
dla_start  out  1  one-cycle DLA start pulse
transfer_config  out  CFG_W  config for current layer, registered
layer_idx  out  $clog2(MAX_LAYERS)  index of current layer
busy  out  1  sequence in progress
seq_done  out  1  one-cycle pulse, all layers complete
timeout_err  out  1  sticky timeout flag
cycle_count  out  CYC_W  cycles spent busy in last/current sequence

Behaviour:
- Reset values: all outputs 0; state IDLE; table contents 0.
- States:
  - IDLE: run=1 -> LOAD. Clears layer_idx, cycle_count, timeout_err, wait counter. Latches n = min(num_layers, MAX_LAYERS). If n==0 -> DONE directly, with no dla_start.
  - LOAD: transfer_config <= table[layer_idx]. -> START.
  - START: dla_start <= 1 for exactly one cycle. -> WAIT.
  - WAIT: layer_done is ignored in the first WAIT cycle, i.e. while dla_start is high. After that, layer_done=1 -> NEXT. Wait counter increments each WAIT cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES -> ERR.
  - NEXT: if layer_idx==n-1 -> DONE, else layer_idx+1 -> LOAD. Wait counter clears.
  - DONE: seq_done=1 for one cycle -> IDLE.
  - ERR: timeout_err<=1 (sticky until next accepted run or rst) -> IDLE. No seq_done.
- Timing: run sampled at edge k. transfer_config is updated at edge k+2; dla_start is high from edge k+3 to k+4. transfer_config is stable from LOAD until the next LOAD or reset; it holds its last value in IDLE.
- Layer-to-layer gap: layer_done sampled at edge j produces the next dla_start at edge j+3.
- busy=1 in every state except IDLE. cycle_count increments every busy cycle, saturates at all-ones, and holds in IDLE.
- abort (any busy state) -> IDLE at the next edge:
  - dla_start is forced 0;
  - no seq_done, no timeout_err;
  - layer_idx holds, for debug.
- abort has priority over layer_done and timeout in the same cycle.
- run while busy is ignored. layer_done outside WAIT is ignored.
- cfg_we is accepted only when busy=0; writes while busy are dropped. A write and run in the same IDLE cycle: the write lands, and the run uses the new value.
- Reset mid-operation returns to IDLE with all outputs 0 immediately (asynchronous).

Decomposition:
- Package dla_seq_pkg:
  - state enum {IDLE, LOAD, START, WAIT, NEXT, DONE, ERR};
  - default CFG_W;
  - the pw-28x28 and dw config constants, so the top-level can preload the table.
- Sub-module dla_cfg_regfile: MAX_LAYERS x CFG_W flop array. It has one synchronous write port and one combinational read port, with write gated by busy externally.

Test Plan:
- Preload table[0]=pw-28x28 config, table[1]=dw config; num_layers=2; run pulse at cycle 10. Pass criteria:
  - dla_start high at cycle 13 with transfer_config=table[0];
  - after layer_done, second dla_start after 3 cycles with table[1];
  - seq_done one cycle after the NEXT state following the second layer_done.
- num_layers=0, run -> busy for 1 cycle, seq_done pulse, dla_start never asserted.
- num_layers=12 with MAX_LAYERS=8 -> exactly 8 dla_start pulses, layer_idx sequence 0..7, then seq_done.
- TIMEOUT_CYCLES=16, no layer_done -> timeout_err=1 after 16 WAIT cycles, busy=0, seq_done stays 0. A new run clears timeout_err.
- Same-cycle checks:
  - abort and layer_done together in WAIT of layer 1 -> IDLE next cycle, no further dla_start, no seq_done, layer_idx=1.
  - layer_done pulse coincident with dla_start -> ignored; sequencer stays in WAIT until the next layer_done.
- cfg_we to addr 0 while busy -> table unchanged, verified by rerun. Asynchronous rst asserted mid-WAIT -> all outputs 0 immediately.
